// File: rtl/ro_pkg.sv
// Shared definitions for the RO drive and monitor blocks: FSM encoding and default timing unit.
package ro_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StHigh = 2'd2,
        StLow  = 2'd3
    } ro_state_e;

    localparam int unsigned UnitDivDefault = 6;

endpackage

// File: rtl/ro_unit_timer.sv
// Nested prescaler + unit counter; done marks the last clk cycle of a target-unit phase.
module ro_unit_timer
    import ro_pkg::*;
#(
    parameter int unsigned UNIT_DIV = UnitDivDefault,
    parameter int unsigned PW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [PW-1:0] target,
    output logic          done
);

    localparam int unsigned    PsW    = (UNIT_DIV > 1) ? $clog2(UNIT_DIV) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(UNIT_DIV - 1);

    logic [PsW-1:0] ps_q, ps_d;
    logic [PW-1:0]  unit_q, unit_d;
    logic           tick;

    assign tick = (ps_q == PsLast);
    // target is never 0 while a phase runs, so target-1 cannot underflow in use
    assign done = tick && (unit_q == target - PW'(1));

    always_comb begin
        ps_d   = ps_q;
        unit_d = unit_q;
        if (clr || done) begin
            ps_d   = '0;
            unit_d = '0;
        end else if (tick) begin
            ps_d   = '0;
            unit_d = unit_q + PW'(1);
        end else begin
            ps_d   = ps_q + PsW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q   <= '0;
            unit_q <= '0;
        end else begin
            ps_q   <= ps_d;
            unit_q <= unit_d;
        end
    end

endmodule

// File: rtl/ro_pulse_driver.sv
// RO drive pulse train: high for period*UNIT_DIV cycles, low for gap*UNIT_DIV, single or continuous.
module ro_pulse_driver
    import ro_pkg::*;
#(
    parameter int unsigned UNIT_DIV = UnitDivDefault,
    parameter int unsigned PW       = 8,
    parameter int unsigned CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cont,
    input  logic          stop,
    input  logic [PW-1:0] period_in,
    input  logic [PW-1:0] gap_in,
    output logic          ro_out,
    output logic          busy,
    output logic          pulse_done,
    output logic          cfg_err,
    output logic [CW-1:0] pulse_count
);

    ro_state_e     state_q, state_d;
    logic          cont_q, cont_d;
    logic          stop_pend_q, stop_pend_d;
    logic [PW-1:0] per_q, per_d;
    logic [PW-1:0] gap_q, gap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ro_q, ro_d;
    logic          pd_q, pd_d;
    logic          cfg_q, cfg_d;

    logic          timer_clr;
    logic [PW-1:0] timer_target;
    logic          phase_done;

    assign timer_clr    = (state_q == StIdle) || (state_q == StLoad);
    assign timer_target = (state_q == StLow) ? gap_q : per_q;

    ro_unit_timer #(
        .UNIT_DIV (UNIT_DIV),
        .PW       (PW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .target (timer_target),
        .done   (phase_done)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start && (period_in != '0)) state_d = StLoad;
            StLoad: state_d = StHigh;
            StHigh: if (phase_done) state_d = StLow;
            StLow: begin
                if (phase_done) state_d = (cont_q && !stop_pend_q) ? StLoad : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: ro_out follows the state being entered so it is registered yet edge-aligned
    always_comb begin
        busy  = (state_q != StIdle);
        ro_d  = (state_d == StHigh);
        pd_d  = (state_q == StHigh) && phase_done;
        cfg_d = (state_q == StIdle) && start && (period_in == '0);
    end

    always_comb begin
        cont_d      = cont_q;
        per_d       = per_q;
        gap_d       = gap_q;
        stop_pend_d = stop_pend_q;
        cnt_d       = cnt_q;
        if (state_q == StIdle && start && (period_in != '0)) begin
            cont_d = cont;
        end
        if (state_q == StLoad) begin
            per_d = period_in;
            gap_d = (gap_in == '0) ? PW'(1) : gap_in;
        end
        // Clearing on the return to idle wins so a late stop cannot leak into the next run
        if (state_q != StIdle && state_d == StIdle) begin
            stop_pend_d = 1'b0;
        end else if (stop && state_q != StIdle) begin
            stop_pend_d = 1'b1;
        end
        if (pd_d) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_q      <= 1'b0;
            per_q       <= '0;
            gap_q       <= '0;
            stop_pend_q <= 1'b0;
            cnt_q       <= '0;
            ro_q        <= 1'b0;
            pd_q        <= 1'b0;
            cfg_q       <= 1'b0;
        end else begin
            cont_q      <= cont_d;
            per_q       <= per_d;
            gap_q       <= gap_d;
            stop_pend_q <= stop_pend_d;
            cnt_q       <= cnt_d;
            ro_q        <= ro_d;
            pd_q        <= pd_d;
            cfg_q       <= cfg_d;
        end
    end

    assign ro_out      = ro_q;
    assign pulse_done  = pd_q;
    assign cfg_err     = cfg_q;
    assign pulse_count = cnt_q;

endmodule

// File: tb/tb_ro_pulse_driver.sv
// Directed bench for ro_pulse_driver: vector table of pulse runs plus hand-written corner sequences.
module tb_ro_pulse_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, cont = 1'b0, stop = 1'b0;
    logic [7:0]  period_in = '0, gap_in = '0;
    logic        ro_out, busy, pulse_done, cfg_err;
    logic [15:0] pulse_count;

    logic        w_start = 1'b0, w_cont = 1'b0, w_stop = 1'b0;
    logic [7:0]  w_per = '0, w_gap = '0;
    logic        w_ro, w_busy, w_pd, w_cfg;
    logic [1:0]  w_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    ro_pulse_driver #(.UNIT_DIV(2), .PW(8), .CW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cont        (cont),
        .stop        (stop),
        .period_in   (period_in),
        .gap_in      (gap_in),
        .ro_out      (ro_out),
        .busy        (busy),
        .pulse_done  (pulse_done),
        .cfg_err     (cfg_err),
        .pulse_count (pulse_count)
    );

    // Full-width build with a narrow counter so the wrap is cheap to reach
    ro_pulse_driver #(.UNIT_DIV(6), .PW(8), .CW(2)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .start       (w_start),
        .cont        (w_cont),
        .stop        (w_stop),
        .period_in   (w_per),
        .gap_in      (w_gap),
        .ro_out      (w_ro),
        .busy        (w_busy),
        .pulse_done  (w_pd),
        .cfg_err     (w_cfg),
        .pulse_count (w_cnt)
    );

    typedef struct {
        logic [7:0] per;
        logic [7:0] gap;
        bit         cont;
        int         stop_done;
        int         stop_high;
        int         exp_high;
        int         exp_low;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called aligned to a negedge; pulses start for one cycle and watches the run to idle
    task automatic run_case(input vec_t v, input string tag);
        int lat = 0, pulses = 0, bad_w = 0, run = 0, low_run = 0, pds = 0, bad_pd = 0, cfgs = 0;
        bit prev_ro = 1'b0, seen_busy = 1'b0, fin = 1'b0;
        period_in = v.per;
        gap_in    = v.gap;
        cont      = v.cont;
        start     = 1'b1;
        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            stop = 1'b0;
            if (ro_out && lat == 0) lat = cyc;
            if (ro_out) begin
                run++;
                low_run = 0;
            end else begin
                if (prev_ro) begin
                    pulses++;
                    if (run != v.exp_high) bad_w++;
                    run = 0;
                end
                if (busy) low_run++;
            end
            if (pulse_done) begin
                pds++;
                if (!(prev_ro && !ro_out)) bad_pd++;
            end
            if (cfg_err) cfgs++;
            if (busy) seen_busy = 1'b1;
            if (seen_busy && !busy) fin = 1'b1;
            if (v.stop_done != 0 && pulse_done && pds == v.stop_done) stop = 1'b1;
            if (v.stop_high != 0 && pulses == 0 && run == v.stop_high) stop = 1'b1;
            prev_ro = ro_out;
        end
        stop = 1'b0;
        exp_cnt += v.exp_pulses;
        check({tag, "_finished"}, fin, 1);
        check({tag, "_latency"}, lat, 2);
        check({tag, "_pulses"}, pulses, v.exp_pulses);
        check({tag, "_bad_width"}, bad_w, 0);
        check({tag, "_final_low"}, low_run, v.exp_low);
        check({tag, "_pulse_done"}, pds, v.exp_pulses);
        check({tag, "_pd_align"}, bad_pd, 0);
        check({tag, "_cfg_err"}, cfgs, 0);
        check({tag, "_count"}, pulse_count, exp_cnt);
    endtask

    initial begin
        int cfgs, bsy, ros, pds, hi;
        bit fin;

        //            per  gap cont sd sh high low n
        vecs[0] = '{8'd3, 8'd2, 1'b0, 0, 0, 6,  4, 1};  // single shot
        vecs[1] = '{8'd1, 8'd0, 1'b1, 3, 0, 2,  2, 3};  // continuous, stop after 3rd
        vecs[2] = '{8'd5, 8'd1, 1'b1, 0, 3, 10, 2, 1};  // stop mid-HIGH
        vecs[3] = '{8'd2, 8'd3, 1'b0, 0, 0, 4,  6, 1};
        vecs[4] = '{8'd1, 8'd0, 1'b0, 0, 0, 2,  2, 1};  // gap 0 clamps to 1

        @(negedge clk);
        check("rst_ro_out", ro_out, 0);
        check("rst_busy", busy, 0);
        check("rst_pulse_done", pulse_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_count", pulse_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_case(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Stop while idle must not arm a stop for the next continuous run
        stop = 1'b1;
        repeat (2) @(negedge clk);
        stop = 1'b0;
        run_case('{8'd1, 8'd1, 1'b1, 2, 0, 2, 2, 2}, "idle_stop");
        @(negedge clk);

        // Config error
        period_in = '0;
        cont      = 1'b0;
        start     = 1'b1;
        cfgs = 0; bsy = 0; ros = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            cfgs += int'(cfg_err);
            bsy  += int'(busy);
            ros  += int'(ro_out);
        end
        check("cfg_err_strobes", cfgs, 1);
        check("cfg_busy", bsy, 0);
        check("cfg_ro_out", ros, 0);

        // Asynchronous reset in the middle of a high phase
        period_in = 8'd5;
        gap_in    = 8'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("prerst_ro_high", ro_out, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ro", ro_out, 0);
        check("rst_async_count", pulse_count, 0);
        check("rst_async_busy", busy, 0);
        exp_cnt = 0;
        pds = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pds += int'(pulse_done);
        end
        check("rst_no_pulse_done", pds, 0);
        rst = 1'b0;
        @(negedge clk);
        run_case('{8'd1, 8'd1, 1'b0, 0, 0, 2, 2, 1}, "post_rst");
        @(negedge clk);

        // Maximum width on the UNIT_DIV=6 build
        w_per   = 8'd255;
        w_gap   = 8'd1;
        w_start = 1'b1;
        hi  = 0;
        fin = 1'b0;
        bsy = 0;
        for (int cyc = 1; cyc <= 2000 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) w_start = 1'b0;
            hi += int'(w_ro);
            if (w_busy) bsy = 1;
            if (bsy != 0 && !w_busy) fin = 1'b1;
        end
        check("wide_finished", fin, 1);
        check("wide_high_cycles", hi, 1530);
        check("wide_count", w_cnt, 1);

        for (int k = 0; k < 3; k++) begin
            w_per   = 8'd1;
            w_gap   = 8'd0;
            w_start = 1'b1;
            fin = 1'b0;
            bsy = 0;
            for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
                @(negedge clk);
                if (cyc == 1) w_start = 1'b0;
                if (w_busy) bsy = 1;
                if (bsy != 0 && !w_busy) fin = 1'b1;
            end
            check($sformatf("wrap_finished%0d", k), fin, 1);
            check($sformatf("wrap_count%0d", k), w_cnt, (k + 2) % 4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
